// File: rtl/pix_corr_ctrl.sv
// ============================================================================
// Module      : pix_corr_ctrl
// Description : Handshake gate and frame controller for a pixel-correction
//               filter. Window data bypasses this block; it only gates
//               up_val/up_rdy -> dn_val/dn_rdy, holds the active threshold
//               stable across a frame and counts completed frames.
//               Optional frame-size checking is enabled by defining the
//               macro PIX_CORR_CTRL_SIZE_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pix_corr_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int THR_DEFAULT = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctl_start,
    input  logic                  ctl_stop,
    input  logic                  ctl_thr_we,
    input  logic [DATA_WIDTH-1:0] ctl_thr,
    input  logic                  up_val,
    output logic                  up_rdy,
    input  logic                  up_sof,
    input  logic                  up_eol,
    input  logic                  up_eof,
    output logic                  dn_val,
    input  logic                  dn_rdy,
    output logic [DATA_WIDTH-1:0] cfg_thr,
    output logic                  sts_busy,
    output logic [15:0]           sts_frame_cnt,
    output logic                  sts_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_stop_pend;
    logic                  w_stop_pend_nxt;
    logic                  w_up_rdy;
    logic                  w_dn_val;
    logic                  w_accept;
    logic                  w_sof_acc;
    logic                  w_eof_acc;
    logic                  w_start;
    logic                  w_thr_direct;
    logic [DATA_WIDTH-1:0] r_thr_pend;
    logic [DATA_WIDTH-1:0] r_cfg_thr;
    logic [15:0]           r_frame_cnt;

    // Handshake gating: stall in IDLE, swallow pre-SOF beats, pass through otherwise
    always_comb begin
        w_up_rdy = 1'b0;
        w_dn_val = 1'b0;
        case (r_state)
            ST_WAIT_SOF: begin
                if (up_sof) begin
                    w_up_rdy = dn_rdy;
                    w_dn_val = up_val;
                end else begin
                    w_up_rdy = 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_up_rdy = dn_rdy;
                w_dn_val = up_val;
            end
            default: begin
                w_up_rdy = 1'b0;
                w_dn_val = 1'b0;
            end
        endcase
    end

    // Reset masks the handshake immediately, even before the state flop settles
    assign up_rdy    = w_up_rdy & ~rst;
    assign dn_val    = w_dn_val & ~rst;

    assign w_accept  = up_val & up_rdy;
    assign w_sof_acc = w_accept & up_sof & (r_state == ST_WAIT_SOF);
    assign w_eof_acc = w_accept & up_eof & (r_state != ST_IDLE);
    assign w_start   = (r_state == ST_IDLE) & ctl_start & ~ctl_stop;

    // A threshold write goes live at once only outside a frame; the SOF edge
    // itself is excluded so the SOF beat and the rest of its frame agree
    assign w_thr_direct = ctl_thr_we &
                          ((r_state == ST_IDLE) |
                           ((r_state == ST_WAIT_SOF) & ~w_sof_acc));

    // Next-state and stop-pending logic
    always_comb begin
        w_state_nxt     = r_state;
        w_stop_pend_nxt = r_stop_pend;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (ctl_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sof_acc) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_eof_acc) begin
                    if (r_stop_pend | ctl_stop) begin
                        w_state_nxt     = ST_IDLE;
                        w_stop_pend_nxt = 1'b0;
                    end
                end else if (ctl_stop) begin
                    w_stop_pend_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_stop_pend_nxt = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end

    // Pending and active threshold; active value only moves at frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thr_pend <= DATA_WIDTH'(THR_DEFAULT);
            r_cfg_thr  <= DATA_WIDTH'(THR_DEFAULT);
        end else begin
            if (ctl_thr_we) begin
                r_thr_pend <= ctl_thr;
            end
            if (w_thr_direct) begin
                r_cfg_thr <= ctl_thr;
            end else if (w_eof_acc) begin
                r_cfg_thr <= ctl_thr_we ? ctl_thr : r_thr_pend;
            end
        end
    end

    // Completed-frame counter, cleared by a start, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_start) begin
            r_frame_cnt <= 16'd0;
        end else if (w_eof_acc) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign cfg_thr       = r_cfg_thr;
    assign sts_busy      = (r_state != ST_IDLE);
    assign sts_frame_cnt = r_frame_cnt;

`ifdef PIX_CORR_CTRL_SIZE_CHK_EN
    localparam int c_col_w  = $clog2(H_ACTIVE) + 1;
    localparam int c_line_w = $clog2(V_ACTIVE) + 1;
    localparam logic [c_col_w-1:0]  c_col_last  = c_col_w'(H_ACTIVE - 1);
    localparam logic [c_line_w-1:0] c_line_last = c_line_w'(V_ACTIVE - 1);

    logic                w_fwd;
    logic [c_col_w-1:0]  r_col;
    logic [c_line_w-1:0] r_line;
    logic [c_col_w-1:0]  w_col_cur;
    logic [c_line_w-1:0] w_line_cur;
    logic                r_err;

    assign w_fwd = w_accept & w_dn_val;

    // An SOF beat is pixel (0,0) regardless of what the counters held
    always_comb begin
        w_col_cur  = up_sof ? '0 : r_col;
        w_line_cur = up_sof ? '0 : r_line;
    end

    // Column/line tracking of forwarded beats and sticky size error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_line <= '0;
            r_err  <= 1'b0;
        end else if (w_start) begin
            r_col  <= '0;
            r_line <= '0;
            r_err  <= 1'b0;
        end else if (w_fwd) begin
            if (up_eol && (w_col_cur != c_col_last)) begin
                r_err <= 1'b1;
            end
            if (up_eof) begin
                if ((w_line_cur != c_line_last) || (w_col_cur != c_col_last)) begin
                    r_err <= 1'b1;
                end
                r_col  <= '0;
                r_line <= '0;
            end else if (up_eol) begin
                r_col  <= '0;
                r_line <= w_line_cur + c_line_w'(1);
            end else begin
                r_col  <= w_col_cur + c_col_w'(1);
                r_line <= w_line_cur;
            end
        end
    end

    assign sts_err = r_err;
`else
    localparam int c_unused_geom = H_ACTIVE + V_ACTIVE;
    logic w_unused_eol;
    assign w_unused_eol = up_eol;
    assign sts_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pix_corr_ctrl.sv
// ============================================================================
// Module      : tb_pix_corr_ctrl
// Description : Scoreboard bench for pix_corr_ctrl with a 4x2 frame geometry.
//               Forwarded beats carry a tag; expected (tag, threshold) pairs
//               are queued at issue time and popped by a monitor on every
//               downstream transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pix_corr_ctrl;

    localparam int DW   = 8;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int THR0 = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctl_start = 1'b0;
    logic          ctl_stop = 1'b0;
    logic          ctl_thr_we = 1'b0;
    logic [DW-1:0] ctl_thr = '0;
    logic          up_val = 1'b0;
    logic          up_rdy;
    logic          up_sof = 1'b0;
    logic          up_eol = 1'b0;
    logic          up_eof = 1'b0;
    logic          dn_val;
    logic          dn_rdy = 1'b0;
    logic [DW-1:0] cfg_thr;
    logic          sts_busy;
    logic [15:0]   sts_frame_cnt;
    logic          sts_err;

    logic [15:0]   tag = '0;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [15:0]   tag;
        logic [DW-1:0] thr;
    } exp_t;
    exp_t sb[$];

    // Reference model: 0 = idle, 1 = waiting for SOF, 2 = in frames
    int            m_state  = 0;
    bit            m_spend  = 0;
    logic [DW-1:0] m_thr    = DW'(THR0);
    logic [DW-1:0] m_pend   = DW'(THR0);
    int            m_frames = 0;
    bit            m_err    = 0;
    int            m_pix    = 0;
    int            m_lines  = 0;

    always #5 clk = ~clk;

    pix_corr_ctrl #(
        .DATA_WIDTH (DW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .THR_DEFAULT(THR0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctl_start    (ctl_start),
        .ctl_stop     (ctl_stop),
        .ctl_thr_we   (ctl_thr_we),
        .ctl_thr      (ctl_thr),
        .up_val       (up_val),
        .up_rdy       (up_rdy),
        .up_sof       (up_sof),
        .up_eol       (up_eol),
        .up_eof       (up_eof),
        .dn_val       (dn_val),
        .dn_rdy       (dn_rdy),
        .cfg_thr      (cfg_thr),
        .sts_busy     (sts_busy),
        .sts_frame_cnt(sts_frame_cnt),
        .sts_err      (sts_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit exp_err();
`ifdef PIX_CORR_CTRL_SIZE_CHK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: every downstream transfer must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dn_val === 1'b1 && dn_rdy) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_dn_beat: got tag %0h expected no beat", tag);
            end else begin
                e = sb.pop_front();
                check("beat_tag", 32'(tag), 32'(e.tag));
                check("beat_thr", 32'(cfg_thr), 32'(e.thr));
            end
        end
    end

    // Model update for one clock edge, from the rules of frame control
    task automatic model_edge(input bit acc, input bit s, input bit l, input bit e,
                              input bit we, input logic [DW-1:0] thr,
                              input bit st, input bit sp);
        bit fwd;
        bit eofacc;
        fwd    = acc && (m_state == 2 || (m_state == 1 && s));
        eofacc = acc && e && (m_state != 0);
        if (we && (m_state == 0 || (m_state == 1 && !(acc && s))))
            m_thr = thr;
        else if (eofacc)
            m_thr = we ? thr : m_pend;
        if (we) m_pend = thr;
        if (eofacc) m_frames = (m_frames + 1) % 65536;
        if (fwd) begin
            if (s) begin
                m_pix   = 0;
                m_lines = 0;
            end
            m_pix++;
            if (e && (m_lines != V - 1 || m_pix != H)) m_err = 1;
            if (l) begin
                if (m_pix != H) m_err = 1;
                m_lines++;
                m_pix = 0;
            end
            if (e) begin
                m_pix   = 0;
                m_lines = 0;
            end
        end
        case (m_state)
            0: if (st && !sp) begin
                m_state  = 1;
                m_frames = 0;
                m_err    = 0;
                m_pix    = 0;
                m_lines  = 0;
            end
            1: if (sp) m_state = 0;
               else if (acc && s) m_state = 2;
            default: begin
                if (eofacc) begin
                    if (m_spend || sp) begin
                        m_state = 0;
                        m_spend = 0;
                    end
                end else if (sp) begin
                    m_spend = 1;
                end
            end
        endcase
    endtask

    // One clock of stimulus, entered and left at posedge+1
    task automatic step(input bit v, input bit s, input bit l, input bit e, input bit dr,
                        input bit we, input logic [DW-1:0] thr, input bit st, input bit sp,
                        output bit acc, output bit dnv);
        up_val = v; up_sof = s; up_eol = l; up_eof = e; dn_rdy = dr;
        ctl_thr_we = we; ctl_thr = thr; ctl_start = st; ctl_stop = sp;
        @(negedge clk);
        acc = v && (up_rdy === 1'b1);
        dnv = (dn_val === 1'b1);
        model_edge(acc, s, l, e, we, thr, st, sp);
        @(posedge clk);
        #1;
        up_val = 0; up_sof = 0; up_eol = 0; up_eof = 0;
        ctl_thr_we = 0; ctl_start = 0; ctl_stop = 0;
    endtask

    task automatic idle_cycles(input int n);
        bit a, d;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom_range(0, 1), 0, '0, 0, 0, a, d);
    endtask

    // Issue one upstream beat and hold it until accepted (bounded)
    task automatic send_beat(input bit s, input bit l, input bit e, input bit force_rdy,
                             input bit we, input logic [DW-1:0] thr, input bit sp);
        bit   acc, dnv, dr, junk;
        int   n;
        exp_t ent;
        n    = 0;
        tag  = tag + 16'd1;
        junk = (m_state == 1) && !s;
        if (m_state == 2 || (m_state == 1 && s)) begin
            ent.tag = tag;
            ent.thr = m_thr;
            sb.push_back(ent);
        end
        do begin
            dr = force_rdy ? 1'b1 : 1'($urandom_range(0, 1));
            step(1, s, l, e, dr, (n == 0) ? we : 1'b0, thr, 0, (n == 0) ? sp : 1'b0, acc, dnv);
            if (junk && n == 0) begin
                check("junk_accepted", 32'(acc), 32'd1);
                check("junk_dn_val", 32'(dnv), 32'd0);
            end
            n++;
        end while (!acc && n < 64);
        if (!acc) check("beat_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input bit force_rdy, input int we_at, input logic [DW-1:0] thr,
                              input int stop_at, input int short_line);
        int k, npix;
        k = 0;
        for (int y = 0; y < V; y++) begin
            npix = (y == short_line) ? H - 1 : H;
            for (int x = 0; x < npix; x++) begin
                send_beat((y == 0 && x == 0), (x == npix - 1), (x == npix - 1 && y == V - 1),
                          force_rdy, (k == we_at), thr, (k == stop_at));
                k++;
            end
        end
    endtask

    task automatic check_status(input string tagname);
        check({tagname, "_frame_cnt"}, 32'(sts_frame_cnt), 32'(m_frames));
        check({tagname, "_busy"}, 32'(sts_busy), 32'(m_state != 0));
        check({tagname, "_cfg_thr"}, 32'(cfg_thr), 32'(m_thr));
        check({tagname, "_err"}, 32'(sts_err), 32'(exp_err()));
    endtask

    task automatic model_reset();
        m_state = 0; m_spend = 0; m_thr = DW'(THR0); m_pend = DW'(THR0);
        m_frames = 0; m_err = 0; m_pix = 0; m_lines = 0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a, d;
        int we_at, stop_at, short_line, njunk;
        logic [DW-1:0] thr;

        // Reset state, with upstream offering a beat
        up_val = 1; dn_rdy = 1;
        #12;
        check("rst_up_rdy", 32'(up_rdy), 32'd0);
        check("rst_dn_val", 32'(dn_val), 32'd0);
        check("rst_busy", 32'(sts_busy), 32'd0);
        check("rst_cfg_thr", 32'(cfg_thr), 32'(THR0));
        check("rst_frame_cnt", 32'(sts_frame_cnt), 32'd0);
        check("rst_err", 32'(sts_err), 32'd0);
        up_val = 0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Start and stop together in IDLE: stays idle, upstream stalled
        step(0, 0, 0, 0, 1, 0, '0, 1, 1, a, d);
        check("start_stop_busy", 32'(sts_busy), 32'd0);
        step(1, 1, 0, 0, 1, 0, '0, 0, 0, a, d);
        check("idle_accept", 32'(a), 32'd0);
        check("idle_dn_val", 32'(d), 32'd0);

        // Start, three pre-SOF beats discarded, then a clean 4x2 frame
        step(0, 0, 0, 0, 1, 0, '0, 1, 0, a, d);
        check("start_busy", 32'(sts_busy), 32'd1);
        for (int i = 0; i < 3; i++) send_beat(0, 0, 0, i != 1, 0, '0, 0);
        send_frame(1, -1, '0, -1, -1);
        check("frame1_cnt", 32'(sts_frame_cnt), 32'd1);
        check_status("frame1");

        // Threshold write mid-frame takes effect only at EOF
        send_frame(1, 3, 8'h30, -1, -1);
        check("thr_mid_frame", 32'(cfg_thr), 32'h30);
        check_status("frame2");

        // Threshold write coinciding with the accepted EOF beat
        send_frame(1, H * V - 1, 8'h44, -1, -1);
        check("thr_at_eof", 32'(cfg_thr), 32'h44);

        // Stop mid-frame with a throttled filter: frame completes, then idle
        send_frame(0, -1, '0, 2, -1);
        check_status("stop");
        step(1, 1, 0, 0, 1, 0, '0, 0, 0, a, d);
        check("after_stop_accept", 32'(a), 32'd0);

        // Threshold write while idle applies on the next cycle
        step(0, 0, 0, 0, 1, 1, 8'h55, 0, 0, a, d);
        check("idle_thr", 32'(cfg_thr), 32'h55);

        // Short line: sticky error (when size checking is built in) until restart
        step(0, 0, 0, 0, 1, 0, '0, 1, 0, a, d);
        check("restart_frame_cnt", 32'(sts_frame_cnt), 32'd0);
        send_frame(1, -1, '0, -1, 0);
        check_status("short");
        send_frame(0, -1, '0, -1, -1);
        check_status("short_sticky");
        send_frame(1, -1, '0, 0 + 1, -1);
        step(0, 0, 0, 0, 1, 0, '0, 1, 0, a, d);
        check_status("err_clear");

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            if (m_state == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    step(0, 0, 0, 0, 1, 1, DW'($urandom), 0, 0, a, d);
                end
                step(0, 0, 0, 0, 1, 0, '0, 1, 0, a, d);
            end
            if (m_state == 1) begin
                njunk = $urandom_range(0, 2);
                for (int j = 0; j < njunk; j++) send_beat(0, 0, 0, 0, 0, '0, 0);
            end
            we_at      = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, H * V - 1));
            stop_at    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, H * V - 1)) : -1;
            short_line = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, V - 1)) : -1;
            thr        = DW'($urandom);
            send_frame(1'($urandom_range(0, 1)), we_at, thr, stop_at, short_line);
            check_status("rand");
            idle_cycles($urandom_range(0, 2));
        end

        // Reset in the middle of a frame aborts it at once
        if (m_state == 0) step(0, 0, 0, 0, 1, 0, '0, 1, 0, a, d);
        send_frame(1, -1, '0, -1, -1);
        send_beat(1, 0, 0, 1, 0, '0, 0);
        send_beat(0, 0, 0, 1, 0, '0, 0);
        up_val = 1; dn_rdy = 1;
        rst = 1;
        #1;
        check("mid_rst_up_rdy", 32'(up_rdy), 32'd0);
        check("mid_rst_dn_val", 32'(dn_val), 32'd0);
        check("mid_rst_busy", 32'(sts_busy), 32'd0);
        check("mid_rst_cfg_thr", 32'(cfg_thr), 32'(THR0));
        check("mid_rst_frame_cnt", 32'(sts_frame_cnt), 32'd0);
        up_val = 0;
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        step(1, 1, 0, 0, 1, 0, '0, 0, 0, a, d);
        check("post_rst_accept", 32'(a), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
